// File: rtl/imem_debug_loader.sv
// Streams a program image into instruction memory over its debug port,
// optionally reading every word back, and keeps the core held until the image is good.
module imem_debug_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024,
    parameter bit          VERIFY    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] word_count,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic        debug_en,
    output logic        debug_write_en,
    output logic [31:0] debug_addr,
    output logic [31:0] debug_data_in,
    input  logic [31:0] debug_data_out,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold,
    output logic [15:0] words_written
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_WORD,
        S_WRITE,
        S_READBACK,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    // word_count is 16 bits, so any larger limit behaves as 65535.
    localparam int unsigned MAX_CLAMP = (MAX_WORDS > 65535) ? 65535 : MAX_WORDS;
    localparam logic [15:0] MAX_W     = 16'(MAX_CLAMP);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [15:0] count_q, count_d;
    logic [15:0] ww_q, ww_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        s_ready_q, busy_q, cpu_hold_q;
    logic        dbg_en_q, dbg_we_q;
    logic [31:0] dbg_addr_q, dbg_din_q;

    logic        start_ok;
    logic [15:0] ww_inc;
    logic        access_d;
    logic        busy_d;

    assign start_ok = (word_count != 16'd0) && (word_count <= MAX_W);
    assign ww_inc   = ww_q + 16'd1;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        ww_d    = ww_q;
        done_d  = done_q;
        error_d = error_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    ww_d    = 16'd0;
                    if (start_ok) begin
                        count_d = word_count;
                        addr_d  = BASE_ADDR;
                        state_d = S_WAIT_WORD;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_ERROR;
                    end
                end
            end
            S_WAIT_WORD: begin
                if (s_valid) begin
                    data_d  = s_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (VERIFY) begin
                    state_d = S_READBACK;
                end else begin
                    ww_d   = ww_inc;
                    addr_d = addr_q + 32'd4;
                    if (ww_inc == count_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_WORD;
                    end
                end
            end
            S_READBACK: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // Advance is folded into this edge so a verified word costs four cycles.
                if (debug_data_out == data_q) begin
                    ww_d   = ww_inc;
                    addr_d = addr_q + 32'd4;
                    if (ww_inc == count_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_WORD;
                    end
                end else begin
                    error_d = 1'b1;
                    state_d = S_ERROR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign access_d = (state_d == S_WRITE) || (state_d == S_READBACK) || (state_d == S_CHECK);
    assign busy_d   = access_d || (state_d == S_WAIT_WORD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            count_q    <= 16'd0;
            ww_q       <= 16'd0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            cpu_hold_q <= 1'b0;
            dbg_en_q   <= 1'b0;
            dbg_we_q   <= 1'b0;
            dbg_addr_q <= 32'd0;
            dbg_din_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            count_q    <= count_d;
            ww_q       <= ww_d;
            done_q     <= done_d;
            error_q    <= error_d;
            s_ready_q  <= (state_d == S_WAIT_WORD);
            busy_q     <= busy_d;
            cpu_hold_q <= busy_d || (state_d == S_ERROR);
            dbg_en_q   <= access_d;
            dbg_we_q   <= (state_d == S_WRITE);
            dbg_addr_q <= access_d ? addr_d : 32'd0;
            dbg_din_q  <= access_d ? data_d : 32'd0;
        end
    end

    assign s_ready        = s_ready_q;
    assign busy           = busy_q;
    assign cpu_hold       = cpu_hold_q;
    assign done           = done_q;
    assign error          = error_q;
    assign words_written  = ww_q;
    assign debug_en       = dbg_en_q;
    assign debug_write_en = dbg_we_q;
    assign debug_addr     = dbg_addr_q;
    assign debug_data_in  = dbg_din_q;

endmodule

// File: tb/tb_imem_debug_loader.sv
// Directed bench: one write-only loader (base 0x0) and one verifying loader (base 0x10),
// each talking to a small memory model with one cycle of read latency.
module tb_imem_debug_loader;

    localparam logic [31:0] JUNK   = 32'hBAD0_BAD0;
    // flag order: busy, s_ready, done, error, cpu_hold, debug_en, debug_write_en
    localparam logic [6:0]  F_IDLE = 7'b0000000;
    localparam logic [6:0]  F_WAIT = 7'b1100100;
    localparam logic [6:0]  F_WR   = 7'b1000111;
    localparam logic [6:0]  F_RD   = 7'b1000110;
    localparam logic [6:0]  F_DONE = 7'b0010000;
    localparam logic [6:0]  F_ERR  = 7'b0001100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        w_start, w_s_valid, w_s_ready, w_en, w_we, w_busy, w_done, w_error, w_hold;
    logic [15:0] w_wc, w_ww;
    logic [31:0] w_s_data, w_addr, w_din, w_dout;
    logic        v_start, v_s_valid, v_s_ready, v_en, v_we, v_busy, v_done, v_error, v_hold;
    logic [15:0] v_wc, v_ww;
    logic [31:0] v_s_data, v_addr, v_din, v_dout;
    logic        v_corrupt;

    logic [6:0] w_flags, v_flags;
    assign w_flags = {w_busy, w_s_ready, w_done, w_error, w_hold, w_en, w_we};
    assign v_flags = {v_busy, v_s_ready, v_done, v_error, v_hold, v_en, v_we};

    logic [31:0] prog [4] = '{32'h0050_0093, 32'h0010_0113, 32'h0020_81B3, 32'hCAFE_BABE};

    logic [31:0] mem_w [64];
    logic [31:0] mem_v [64];
    int junk_writes = 0;

    always @(posedge clk) begin
        if (w_en && w_we) mem_w[w_addr[7:2]] <= w_din;
        w_dout <= mem_w[w_addr[7:2]];
        if (w_en && w_we && w_din == JUNK) junk_writes <= junk_writes + 1;
    end

    always @(posedge clk) begin
        if (v_en && v_we) mem_v[v_addr[7:2]] <= v_din;
        v_dout <= (v_corrupt && v_addr == 32'h14) ? 32'hDEAD_BEEF : mem_v[v_addr[7:2]];
    end

    imem_debug_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(8), .VERIFY(1'b0)) dut_w (
        .clk(clk), .reset(reset), .start(w_start), .word_count(w_wc),
        .s_valid(w_s_valid), .s_data(w_s_data), .s_ready(w_s_ready),
        .debug_en(w_en), .debug_write_en(w_we), .debug_addr(w_addr),
        .debug_data_in(w_din), .debug_data_out(w_dout),
        .busy(w_busy), .done(w_done), .error(w_error), .cpu_hold(w_hold),
        .words_written(w_ww)
    );

    imem_debug_loader #(.BASE_ADDR(32'h10), .MAX_WORDS(8), .VERIFY(1'b1)) dut_v (
        .clk(clk), .reset(reset), .start(v_start), .word_count(v_wc),
        .s_valid(v_s_valid), .s_data(v_s_data), .s_ready(v_s_ready),
        .debug_en(v_en), .debug_write_en(v_we), .debug_addr(v_addr),
        .debug_data_in(v_din), .debug_data_out(v_dout),
        .busy(v_busy), .done(v_done), .error(v_error), .cpu_hold(v_hold),
        .words_written(v_ww)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        if ({w_flags, w_addr, w_din, w_ww} !== '0) begin
            errors++;
            $display("FAIL reset_w flags=%b addr=%h din=%h ww=%0d exp all zero", w_flags, w_addr, w_din, w_ww);
        end
        checks++;
        if ({v_flags, v_addr, v_din, v_ww} !== '0) begin
            errors++;
            $display("FAIL reset_v flags=%b addr=%h din=%h ww=%0d exp all zero", v_flags, v_addr, v_din, v_ww);
        end
        checks++;
        reset = 1'b0;
        tick();
        if (w_flags !== F_IDLE || v_flags !== F_IDLE) begin
            errors++;
            $display("FAIL idle_after_reset w=%b v=%b exp %b", w_flags, v_flags, F_IDLE);
        end
        checks++;
    endtask

    task automatic test_write_only;
        w_wc = 16'd3; w_start = 1'b1; w_s_valid = 1'b1; w_s_data = prog[0];
        tick();
        w_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w_s_data = prog[i];
            if (w_flags !== F_WAIT || w_ww !== 16'(i)) begin
                errors++;
                $display("FAIL wo_wait[%0d] flags=%b ww=%0d exp flags=%b ww=%0d", i, w_flags, w_ww, F_WAIT, i);
            end
            checks++;
            tick();
            if (w_flags !== F_WR || w_addr !== 32'(4 * i) || w_din !== prog[i]) begin
                errors++;
                $display("FAIL wo_write[%0d] flags=%b addr=%h din=%h exp flags=%b addr=%h din=%h",
                         i, w_flags, w_addr, w_din, F_WR, 4 * i, prog[i]);
            end
            checks++;
            tick();
        end
        w_s_valid = 1'b0;
        if (w_flags !== F_DONE || w_ww !== 16'd3) begin
            errors++;
            $display("FAIL wo_done flags=%b ww=%0d exp flags=%b ww=3", w_flags, w_ww, F_DONE);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            if (mem_w[i] !== prog[i]) begin
                errors++;
                $display("FAIL wo_mem[%0d] got=%h exp=%h", i, mem_w[i], prog[i]);
            end
            checks++;
        end
    endtask

    task automatic test_verified;
        v_wc = 16'd4; v_start = 1'b1; v_s_valid = 1'b1; v_s_data = prog[0];
        tick();
        v_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v_s_data = prog[i];
            if (v_flags !== F_WAIT || v_ww !== 16'(i)) begin
                errors++;
                $display("FAIL vf_wait[%0d] flags=%b ww=%0d exp flags=%b ww=%0d", i, v_flags, v_ww, F_WAIT, i);
            end
            checks++;
            tick();
            if (v_flags !== F_WR || v_addr !== 32'(16 + 4 * i) || v_din !== prog[i]) begin
                errors++;
                $display("FAIL vf_write[%0d] flags=%b addr=%h din=%h exp flags=%b addr=%h din=%h",
                         i, v_flags, v_addr, v_din, F_WR, 16 + 4 * i, prog[i]);
            end
            checks++;
            tick();
            if (v_flags !== F_RD || v_addr !== 32'(16 + 4 * i)) begin
                errors++;
                $display("FAIL vf_readback[%0d] flags=%b addr=%h exp flags=%b addr=%h", i, v_flags, v_addr, F_RD, 16 + 4 * i);
            end
            checks++;
            tick();
            if (v_flags !== F_RD || v_addr !== 32'(16 + 4 * i)) begin
                errors++;
                $display("FAIL vf_check[%0d] flags=%b addr=%h exp flags=%b addr=%h", i, v_flags, v_addr, F_RD, 16 + 4 * i);
            end
            checks++;
            tick();
        end
        v_s_valid = 1'b0;
        if (v_flags !== F_DONE || v_ww !== 16'd4) begin
            errors++;
            $display("FAIL vf_done flags=%b ww=%0d exp flags=%b ww=4", v_flags, v_ww, F_DONE);
        end
        checks++;
        if (mem_v[7] !== 32'hCAFE_BABE) begin
            errors++;
            $display("FAIL vf_mem3 got=%h exp=cafebabe", mem_v[7]);
        end
        checks++;
    endtask

    task automatic test_mismatch;
        int bad;
        v_corrupt = 1'b1;
        v_wc = 16'd3; v_start = 1'b1; v_s_valid = 1'b1; v_s_data = prog[0];
        tick();
        v_start = 1'b0;
        repeat (4) tick();
        if (v_flags !== F_WAIT || v_ww !== 16'd1) begin
            errors++;
            $display("FAIL mm_first_word flags=%b ww=%0d exp flags=%b ww=1", v_flags, v_ww, F_WAIT);
        end
        checks++;
        v_s_data = prog[1];
        repeat (4) tick();
        if (v_flags !== F_ERR || v_ww !== 16'd1) begin
            errors++;
            $display("FAIL mm_error flags=%b ww=%0d exp flags=%b ww=1", v_flags, v_ww, F_ERR);
        end
        checks++;
        bad = 0;
        repeat (5) begin
            tick();
            if (v_en || v_s_ready || !v_hold || !v_error) bad++;
        end
        if (bad != 0) begin
            errors++;
            $display("FAIL mm_hold_quiet bad_cycles=%0d exp 0", bad);
        end
        checks++;
        v_corrupt = 1'b0;
        v_s_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        w_wc = 16'd3; w_start = 1'b1; w_s_valid = 1'b0; w_s_data = JUNK;
        tick();
        w_start = 1'b0;
        w_s_valid = 1'b1; w_s_data = 32'h1111_0001;
        tick();
        if (w_flags !== F_WR || w_addr !== 32'h0 || w_din !== 32'h1111_0001) begin
            errors++;
            $display("FAIL bp_write0 flags=%b addr=%h din=%h exp flags=%b addr=0 din=11110001", w_flags, w_addr, w_din, F_WR);
        end
        checks++;
        w_s_valid = 1'b0; w_s_data = JUNK;
        tick();
        w_start = 1'b1; w_wc = 16'd5;
        tick();
        w_start = 1'b0;
        if (w_flags !== F_WAIT || w_ww !== 16'd1) begin
            errors++;
            $display("FAIL bp_start_ignored flags=%b ww=%0d exp flags=%b ww=1", w_flags, w_ww, F_WAIT);
        end
        checks++;
        w_s_valid = 1'b1; w_s_data = 32'h2222_0002;
        tick();
        if (w_flags !== F_WR || w_addr !== 32'h4 || w_din !== 32'h2222_0002) begin
            errors++;
            $display("FAIL bp_write1 flags=%b addr=%h din=%h exp flags=%b addr=4 din=22220002", w_flags, w_addr, w_din, F_WR);
        end
        checks++;
        w_s_valid = 1'b0; w_s_data = JUNK;
        tick();
        w_s_valid = 1'b1; w_s_data = 32'h3333_0003;
        tick();
        if (w_flags !== F_WR || w_addr !== 32'h8 || w_din !== 32'h3333_0003) begin
            errors++;
            $display("FAIL bp_write2 flags=%b addr=%h din=%h exp flags=%b addr=8 din=33330003", w_flags, w_addr, w_din, F_WR);
        end
        checks++;
        w_s_valid = 1'b0; w_s_data = JUNK;
        tick();
        if (w_flags !== F_DONE || w_ww !== 16'd3) begin
            errors++;
            $display("FAIL bp_done flags=%b ww=%0d exp flags=%b ww=3", w_flags, w_ww, F_DONE);
        end
        checks++;
        if (mem_w[0] !== 32'h1111_0001 || mem_w[1] !== 32'h2222_0002 || mem_w[2] !== 32'h3333_0003 || junk_writes != 0) begin
            errors++;
            $display("FAIL bp_mem got=%h %h %h junk_writes=%0d exp 11110001 22220002 33330003 0",
                     mem_w[0], mem_w[1], mem_w[2], junk_writes);
        end
        checks++;
    endtask

    task automatic test_illegal;
        int bad;
        bad = 0;
        w_wc = 16'd0; w_start = 1'b1;
        tick();
        w_start = 1'b0;
        if (w_flags !== F_ERR) begin
            errors++;
            $display("FAIL ill_zero flags=%b exp %b", w_flags, F_ERR);
        end
        checks++;
        tick();
        if (w_en) bad++;
        w_wc = 16'd9; w_start = 1'b1;
        tick();
        w_start = 1'b0;
        if (w_flags !== F_ERR) begin
            errors++;
            $display("FAIL ill_over flags=%b exp %b", w_flags, F_ERR);
        end
        checks++;
        tick();
        if (w_en) bad++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ill_no_access en_cycles=%0d exp 0", bad);
        end
        checks++;
        w_wc = 16'd8; w_start = 1'b1;
        tick();
        w_start = 1'b0;
        if (w_flags !== F_WAIT || w_ww !== 16'd0) begin
            errors++;
            $display("FAIL max_start flags=%b ww=%0d exp flags=%b ww=0", w_flags, w_ww, F_WAIT);
        end
        checks++;
        w_s_valid = 1'b1;
        for (int n = 0; n < 40 && !w_done; n++) begin
            w_s_data = 32'h1000_0000 | {16'h0, w_ww};
            tick();
        end
        w_s_valid = 1'b0;
        if (w_done !== 1'b1 || w_ww !== 16'd8) begin
            errors++;
            $display("FAIL max_load done=%b ww=%0d exp done=1 ww=8", w_done, w_ww);
        end
        checks++;
        if (mem_w[0] !== 32'h1000_0000 || mem_w[7] !== 32'h1000_0007) begin
            errors++;
            $display("FAIL max_mem got=%h %h exp 10000000 10000007", mem_w[0], mem_w[7]);
        end
        checks++;
    endtask

    task automatic test_reset_mid_load;
        v_wc = 16'd3; v_start = 1'b1; v_s_valid = 1'b1; v_s_data = prog[0];
        tick();
        v_start = 1'b0;
        repeat (4) tick();
        v_s_data = prog[1];
        repeat (4) tick();
        v_s_data = prog[2];
        tick();
        if (v_flags !== F_WR || v_ww !== 16'd2) begin
            errors++;
            $display("FAIL rst_pre flags=%b ww=%0d exp flags=%b ww=2", v_flags, v_ww, F_WR);
        end
        checks++;
        #1 reset = 1'b1;
        #1;
        if ({v_flags, v_addr, v_din, v_ww} !== '0) begin
            errors++;
            $display("FAIL rst_async flags=%b addr=%h din=%h ww=%0d exp all zero", v_flags, v_addr, v_din, v_ww);
        end
        checks++;
        tick();
        reset = 1'b0;
        v_wc = 16'd1; v_start = 1'b1; v_s_data = 32'h0BAD_F00D;
        tick();
        v_start = 1'b0;
        tick();
        if (v_flags !== F_WR || v_addr !== 32'h10 || v_din !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL rst_restart flags=%b addr=%h din=%h exp flags=%b addr=10 din=0badf00d", v_flags, v_addr, v_din, F_WR);
        end
        checks++;
        repeat (3) tick();
        v_s_valid = 1'b0;
        if (v_flags !== F_DONE || v_ww !== 16'd1) begin
            errors++;
            $display("FAIL rst_reload_done flags=%b ww=%0d exp flags=%b ww=1", v_flags, v_ww, F_DONE);
        end
        checks++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        w_start = 1'b0; w_wc = 16'd0; w_s_valid = 1'b0; w_s_data = 32'd0;
        v_start = 1'b0; v_wc = 16'd0; v_s_valid = 1'b0; v_s_data = 32'd0;
        v_corrupt = 1'b0;
        test_reset();
        test_write_only();
        test_verified();
        test_mismatch();
        test_back_to_back();
        test_illegal();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
